// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream to vector assembler.
//   state_e   : assembler states (COLLECT accepts beats, DISCARD drops
//               beats until the end of an oversized frame).
//   slice_idx : maps a 0-based beat number onto the vector slice it fills.
package axis_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DISCARD = 1'b1
  } state_e;

  // Beat k lands in slice k (LSB first) or slice n-1-k (MSB first).
  function automatic int unsigned slice_idx(input int unsigned k,
                                            input int unsigned n,
                                            input bit          msb_first);
    return msb_first ? (n - 1 - k) : k;
  endfunction

endpackage

// File: rtl/axis_to_vector.sv
// Collects N = VEC_BYTES/AXIS_BYTES stream beats into one wide vector.
// A frame must be exactly N beats terminated by tlast; shorter frames pulse
// err_short, longer frames pulse err_long and are dropped through tlast.
// Ports:
//   clk, sresetn          : clock, asynchronous active-low reset
//   axis_tvalid/tready    : stream handshake
//   axis_tlast, axis_tdata: end-of-frame marker and beat payload
//   vec, vec_valid        : assembled vector and its valid flag
//   vec_ready             : consumer accepts vec when vec_valid is high
//   err_short, err_long   : one-cycle framing error pulses
// VEC_BYTES must be an integer multiple of AXIS_BYTES.
module axis_to_vector
  import axis_pkg::*;
#(
  parameter int VEC_BYTES  = 4,
  parameter int AXIS_BYTES = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    sresetn,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic                    axis_tlast,
  input  logic [AXIS_BYTES*8-1:0] axis_tdata,
  output logic [VEC_BYTES*8-1:0]  vec,
  output logic                    vec_valid,
  input  logic                    vec_ready,
  output logic                    err_short,
  output logic                    err_long
);

  localparam int unsigned N     = VEC_BYTES / AXIS_BYTES;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BW    = AXIS_BYTES * 8;
  localparam int unsigned VW    = VEC_BYTES * 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VW-1:0]    stage_q, stage_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  // Goes high on the first edge after reset release so tready never
  // rises while reset is still asserted or in the release cycle.
  logic             rdy_q;

  int unsigned      wr_idx;
  logic [VW-1:0]    merged;
  logic             last_beat;
  logic             accept;

  assign wr_idx    = slice_idx(32'(cnt_q), N, MSB_FIRST != 0);
  assign last_beat = (cnt_q == CNT_LAST);

  // The final beat may only be taken if vec is free or being consumed this
  // cycle, which makes tready depend combinationally on vec_ready.
  assign axis_tready = rdy_q &&
                       ((state_q == DISCARD) ||
                        !(last_beat && vec_valid_q && !vec_ready));
  assign accept      = axis_tvalid && axis_tready;

  // Staging register with the current beat inserted at its slice.
  always_comb begin
    merged = stage_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (i == wr_idx) merged[i*BW +: BW] = axis_tdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_d     = stage_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q && !vec_ready;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (!last_beat) begin
            if (axis_tlast) begin
              err_short_d = 1'b1;
              cnt_d       = '0;
            end else begin
              stage_d = merged;
              cnt_d   = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
            if (axis_tlast) begin
              vec_d       = merged;
              vec_valid_d = 1'b1;
            end else begin
              err_long_d = 1'b1;
              state_d    = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (accept && axis_tlast) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      rdy_q       <= 1'b1;
    end
  end

  // Partial-frame contents are always fully overwritten before use.
  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_axis_to_vector.sv
module tb_axis_to_vector;

  logic        clk = 1'b0;
  logic        sresetn;
  logic        axis_tvalid, axis_tlast, vec_ready;
  logic [7:0]  axis_tdata;

  logic        tready0, vv0, es0, el0;
  logic [31:0] vec0;
  logic        tready1, vv1, es1, el1;
  logic [31:0] vec1;

  always #5 clk = ~clk;

  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .sresetn(sresetn), .axis_tvalid(axis_tvalid), .axis_tready(tready0),
    .axis_tlast(axis_tlast), .axis_tdata(axis_tdata), .vec(vec0), .vec_valid(vv0),
    .vec_ready(vec_ready), .err_short(es0), .err_long(el0));

  axis_to_vector #(.VEC_BYTES(4), .AXIS_BYTES(1), .MSB_FIRST(1)) dut1 (
    .clk(clk), .sresetn(sresetn), .axis_tvalid(axis_tvalid), .axis_tready(tready1),
    .axis_tlast(axis_tlast), .axis_tdata(axis_tdata), .vec(vec1), .vec_valid(vv1),
    .vec_ready(vec_ready), .err_short(es1), .err_long(el1));

  int checks = 0;
  int errors = 0;

  logic [31:0] got0[$], got1[$], exp0[$], exp1[$];
  int es0_n, el0_n, es1_n, el1_n, both_n, vv_cycles, tr_div;
  int exp_short, exp_long;

  // Observer: records delivered vectors and error pulses mid-cycle.
  always @(negedge clk) begin
    if (vv0 && vec_ready) got0.push_back(vec0);
    if (vv1 && vec_ready) got1.push_back(vec1);
    if (vv0) vv_cycles++;
    if (es0) es0_n++;
    if (el0) el0_n++;
    if (es1) es1_n++;
    if (el1) el1_n++;
    if ((es0 && el0) || (es1 && el1)) both_n++;
    if (tready0 !== tready1) tr_div++;
  end

  task automatic clear_obs();
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
    es0_n = 0; el0_n = 0; es1_n = 0; el1_n = 0;
    both_n = 0; vv_cycles = 0; tr_div = 0;
    exp_short = 0; exp_long = 0;
  endtask

  task automatic idle();
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tlast  = last;
    @(negedge clk);
    while (tready0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL beat_timeout tready=%b required=1", tready0);
    end
    @(posedge clk); #1;
  endtask

  // Sends one frame and records what the specification says must come out.
  task automatic send_frame(input logic [7:0] d[8], input int len, input bit gaps);
    for (int k = 0; k < len; k++) begin
      send_beat(d[k], k == len - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    idle();
    if (len == 4) begin
      exp0.push_back({d[3], d[2], d[1], d[0]});
      exp1.push_back({d[0], d[1], d[2], d[3]});
    end else if (len < 4) begin
      exp_short++;
    end else begin
      exp_long++;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sresetn = 1'b0; axis_tvalid = 1'b0; axis_tlast = 1'b0;
    axis_tdata = 8'h00; vec_ready = 1'b1;
    settle(3);
    checks++; if (tready0 !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b required=0", tready0); end
    checks++; if (vv0 !== 1'b0) begin errors++; $display("FAIL rst_vec_valid got=%b required=0", vv0); end
    checks++; if (vec0 !== 32'h0) begin errors++; $display("FAIL rst_vec got=%h required=0", vec0); end
    checks++; if ({es0, el0, es1, el1} !== 4'b0) begin errors++; $display("FAIL rst_err got=%b required=0000", {es0, el0, es1, el1}); end
    sresetn = 1'b1;
    #1;
    checks++; if (tready0 !== 1'b0) begin errors++; $display("FAIL rel_tready_early got=%b required=0", tready0); end
    @(posedge clk); #1;
    checks++; if (tready0 !== 1'b1) begin errors++; $display("FAIL rel_tready got=%b required=1", tready0); end
  endtask

  task automatic test_basic();
    logic [7:0] d[8];
    clear_obs();
    vec_ready = 1'b1;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 4, 1'b0);
    settle(4);
    checks++;
    if (got0.size() != 1 || got1.size() != 1) begin
      errors++; $display("FAIL basic_count got=%0d/%0d required=1/1", got0.size(), got1.size());
    end else begin
      checks++; if (got0[0] !== 32'h44332211) begin errors++; $display("FAIL basic_lsb got=%h required=44332211", got0[0]); end
      checks++; if (got1[0] !== 32'h11223344) begin errors++; $display("FAIL basic_msb got=%h required=11223344", got1[0]); end
    end
    checks++; if (vv_cycles != 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d required=1", vv_cycles); end
  endtask

  task automatic test_short();
    logic [7:0] d[8];
    clear_obs();
    vec_ready = 1'b1;
    d = '{8'h01, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 2, 1'b0);
    d = '{8'ha1, 8'hb2, 8'hc3, 8'hd4, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 4, 1'b0);
    settle(4);
    checks++; if (es0_n != 1 || es1_n != 1) begin errors++; $display("FAIL short_pulse got=%0d/%0d required=1/1", es0_n, es1_n); end
    checks++; if (el0_n != 0) begin errors++; $display("FAIL short_nolong got=%0d required=0", el0_n); end
    checks++;
    if (got0.size() != 1 || got1.size() != 1) begin
      errors++; $display("FAIL short_count got=%0d required=1", got0.size());
    end else begin
      checks++; if (got0[0] !== 32'hd4c3b2a1) begin errors++; $display("FAIL short_vec got=%h required=d4c3b2a1", got0[0]); end
      checks++; if (got1[0] !== 32'ha1b2c3d4) begin errors++; $display("FAIL short_vec_msb got=%h required=a1b2c3d4", got1[0]); end
    end
  endtask

  task automatic test_long();
    logic [7:0] d[8];
    clear_obs();
    vec_ready = 1'b1;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    checks++; if (el0 !== 1'b1 || es0 !== 1'b0) begin errors++; $display("FAIL long_after4 got=%b%b required=10", el0, es0); end
    send_beat(8'h05, 1'b1);
    idle();
    settle(4);
    checks++; if (el0_n != 1 || el1_n != 1) begin errors++; $display("FAIL long_pulse got=%0d/%0d required=1/1", el0_n, el1_n); end
    checks++; if (vv_cycles != 0 || got0.size() != 0) begin errors++; $display("FAIL long_novec got=%0d required=0", vv_cycles); end
    d = '{8'h5a, 8'h6b, 8'h7c, 8'h8d, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 4, 1'b0);
    settle(4);
    checks++;
    if (got0.size() != 1) begin
      errors++; $display("FAIL long_recover_count got=%0d required=1", got0.size());
    end else begin
      checks++; if (got0[0] !== 32'h8d7c6b5a) begin errors++; $display("FAIL long_recover got=%h required=8d7c6b5a", got0[0]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    vec_ready = 1'b0;
    send_beat(8'h10, 1'b0); send_beat(8'h20, 1'b0);
    send_beat(8'h30, 1'b0); send_beat(8'h40, 1'b1);
    send_beat(8'h50, 1'b0); send_beat(8'h60, 1'b0); send_beat(8'h70, 1'b0);
    axis_tvalid = 1'b1; axis_tdata = 8'h80; axis_tlast = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (tready0 !== 1'b0) begin errors++; $display("FAIL bp_tready c=%0d got=%b required=0", c, tready0); end
      checks++; if (vv0 !== 1'b1 || vec0 !== 32'h40302010) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%h required=1/40302010", c, vv0, vec0); end
    end
    @(posedge clk); #1;
    vec_ready = 1'b1;
    @(negedge clk);
    checks++; if (tready0 !== 1'b1) begin errors++; $display("FAIL bp_release got=%b required=1", tready0); end
    @(posedge clk); #1;
    idle();
    checks++; if (vv0 !== 1'b1 || vec0 !== 32'h80706050) begin errors++; $display("FAIL bp_nobubble got=%b/%h required=1/80706050", vv0, vec0); end
    checks++; if (vec1 !== 32'h50607080) begin errors++; $display("FAIL bp_msb got=%h required=50607080", vec1); end
    settle(3);
    checks++;
    if (got0.size() != 2) begin
      errors++; $display("FAIL bp_count got=%0d required=2", got0.size());
    end else begin
      checks++; if (got0[0] !== 32'h40302010 || got0[1] !== 32'h80706050) begin errors++; $display("FAIL bp_seq got=%h,%h required=40302010,80706050", got0[0], got0[1]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] d[8];
    bit done;
    clear_obs();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int len;
          len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 4;
          for (int k = 0; k < 8; k++) d[k] = 8'($urandom);
          send_frame(d, len, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          vec_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    vec_ready = 1'b1;
    settle(5);
    checks++;
    if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
      errors++; $display("FAIL rand_count got=%0d/%0d required=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size());
    end else begin
      for (int i = 0; i < exp0.size(); i++) begin
        checks++; if (got0[i] !== exp0[i]) begin errors++; $display("FAIL rand_lsb i=%0d got=%h required=%h", i, got0[i], exp0[i]); end
        checks++; if (got1[i] !== exp1[i]) begin errors++; $display("FAIL rand_msb i=%0d got=%h required=%h", i, got1[i], exp1[i]); end
      end
    end
    checks++; if (es0_n != exp_short || es1_n != exp_short) begin errors++; $display("FAIL rand_short got=%0d/%0d required=%0d", es0_n, es1_n, exp_short); end
    checks++; if (el0_n != exp_long || el1_n != exp_long) begin errors++; $display("FAIL rand_long got=%0d/%0d required=%0d", el0_n, el1_n, exp_long); end
    checks++; if (both_n != 0) begin errors++; $display("FAIL rand_both_err got=%0d required=0", both_n); end
    checks++; if (tr_div != 0) begin errors++; $display("FAIL rand_tready_agree got=%0d required=0", tr_div); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[8];
    clear_obs();
    vec_ready = 1'b0;
    d = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 4, 1'b0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    idle();
    checks++; if (vv0 !== 1'b1 || vec0 !== 32'hefbeadde) begin errors++; $display("FAIL mid_pre got=%b/%h required=1/efbeadde", vv0, vec0); end
    @(negedge clk); #2;
    sresetn = 1'b0;
    #1;
    checks++; if (vv0 !== 1'b0 || vv1 !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b%b required=00", vv0, vv1); end
    checks++; if (vec0 !== 32'h0 || vec1 !== 32'h0) begin errors++; $display("FAIL mid_vec got=%h/%h required=0/0", vec0, vec1); end
    checks++; if (tready0 !== 1'b0) begin errors++; $display("FAIL mid_tready got=%b required=0", tready0); end
    settle(2);
    sresetn = 1'b1;
    settle(1);
    vec_ready = 1'b1;
    d = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(d, 4, 1'b0);
    settle(4);
    checks++; if (es0_n != 0 || el0_n != 0) begin errors++; $display("FAIL mid_noerr got=%0d/%0d required=0/0", es0_n, el0_n); end
    checks++;
    if (got0.size() != 1) begin
      errors++; $display("FAIL mid_count got=%0d required=1", got0.size());
    end else begin
      checks++; if (got0[0] !== 32'h78563412) begin errors++; $display("FAIL mid_vec_after got=%h required=78563412", got0[0]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_to_vector.md
AXIS_TO_VECTOR -- requirements
Module: axis_to_vector

Interface
REQ-001 SHALL have parameter VEC_BYTES, default 4: output vector width in bytes.
REQ-002 SHALL have parameter AXIS_BYTES, default 1: stream beat width in bytes; VEC_BYTES SHALL be an integer multiple of AXIS_BYTES.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 1 = first beat fills the most-significant slice.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port sresetn, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port axis_tvalid, input, 1: beat valid.
REQ-007 SHALL have port axis_tready, output, 1: beat accepted when tvalid and tready are both high.
REQ-008 SHALL have port axis_tlast, input, 1: final beat of a frame.
REQ-009 SHALL have port axis_tdata, input, AXIS_BYTES*8: beat payload.
REQ-010 SHALL have port vec, output, VEC_BYTES*8: assembled vector.
REQ-011 SHALL have port vec_valid, output, 1: vec holds an unconsumed frame.
REQ-012 SHALL have port vec_ready, input, 1: consumer accepts vec when vec_valid and vec_ready are both high.
REQ-013 SHALL have port err_short, output, 1: one-cycle pulse, frame ended before N beats.
REQ-014 SHALL have port err_long, output, 1: one-cycle pulse, frame exceeded N beats.

Function
REQ-015 N = VEC_BYTES/AXIS_BYTES beats per frame; the beat counter SHALL be max(1,clog2(N)) bits wide.
REQ-016 Beat k (0-based) SHALL be written to slice k when MSB_FIRST=0 and to slice N-1-k when MSB_FIRST=1; slice i = bits [(i+1)*AXIS_BYTES*8-1 : i*AXIS_BYTES*8].
REQ-017 Beats SHALL assemble in a staging register separate from the vec output register.
REQ-018 States: COLLECT (accepting beats) and DISCARD (dropping beats until tlast).
REQ-019 COLLECT, accepted beat k<N-1 with tlast=0: store the slice and increment the counter.
REQ-020 COLLECT, accepted beat k<N-1 with tlast=1: pulse err_short the next cycle, discard the partial frame, reset the counter to 0, stay in COLLECT.
REQ-021 COLLECT, accepted beat N-1 with tlast=1: load the complete vector into vec, set vec_valid the next cycle, reset the counter to 0.
REQ-022 COLLECT, accepted beat N-1 with tlast=0: pulse err_long, drop the frame, go to DISCARD.
REQ-023 DISCARD: axis_tready=1; on an accepted beat with tlast=1, return to COLLECT with the counter at 0.
REQ-024 In COLLECT, axis_tready SHALL be low only when the counter is N-1, vec_valid=1 and vec_ready=0; this depends combinationally on vec_ready.
REQ-025 A frame completing in the same cycle that vec is consumed SHALL replace vec with vec_valid held at 1, giving zero bubbles; full throughput is one beat per cycle.
REQ-026 vec and vec_valid SHALL remain stable while vec_valid=1 and vec_ready=0.
REQ-027 N=1: every beat is a complete frame; a beat with tlast=0 SHALL raise err_long.
REQ-028 err_short and err_long SHALL never assert in the same cycle.

Reset
REQ-029 Asserting sresetn low SHALL immediately force: state COLLECT, counter 0, vec_valid 0, vec 0, err_short 0, err_long 0, axis_tready 0.
REQ-030 axis_tready SHALL rise no earlier than the first clock edge after sresetn deasserts.
REQ-031 A partial frame in progress at reset SHALL be lost with no error pulse.

Structure
REQ-032 The state enumeration SHALL live in shared package axis_pkg; N and the counter width SHALL be local parameters.
REQ-033 No sub-module is required; the slice-index calculation MAY be a function in axis_pkg.

Verification
REQ-034 VEC_BYTES=4, AXIS_BYTES=1, MSB_FIRST=0, vec_ready=1, beats 11,22,33,44 with tlast on beat 44 -> vec=0x44332211, vec_valid high for 1 cycle.
REQ-035 Same stimulus with MSB_FIRST=1 -> vec=0x11223344.
REQ-036 Beats 01,02 with tlast on 02, then a valid 4-beat frame -> err_short pulse, then only the second frame is delivered.
REQ-037 Five beats with tlast on the 5th -> err_long after the 4th beat, 5th beat discarded, no vec_valid.
REQ-038 vec_ready=0 and two back-to-back frames -> tready drops on beat 3 of frame 2 and the first vec holds; after vec_ready=1, frame 2 completes with no bubble.
REQ-039 Reset asserted mid-frame after 2 beats -> outputs clear asynchronously; the next full frame assembles correctly.
